// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises and deglitches the pins, deframes 11-bit frames and
// folds E0/F0 prefixes into flags on a single strobed key event.
module ps2_scancode_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 32000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clkps2,
    input  logic       dataps2,
    output logic [7:0] scancode,
    output logic       extended,
    output logic       released,
    output logic       scancode_valid,
    output logic       frame_error
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StData   = 2'd1;
    localparam logic [1:0] StParity = 2'd2;
    localparam logic [1:0] StStop   = 2'd3;

    logic                  clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
    logic [FILTER_LEN-1:0] hist_q;
    logic                  filt_q, filt_d;
    logic                  fall;
    logic [1:0]            state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic [TmoW-1:0]       tmo_q, tmo_d;
    logic                  ext_q, ext_d, rel_q, rel_d;
    logic                  valid_set, err_set;

    always_comb begin
        filt_d = filt_q;
        if (hist_q == '0) begin
            filt_d = 1'b0;
        end else if (&hist_q) begin
            filt_d = 1'b1;
        end
    end

    // Fires in the cycle the filtered level is about to drop.
    assign fall = filt_q & (hist_q == '0);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        ext_d     = ext_q;
        rel_d     = rel_q;
        valid_set = 1'b0;
        err_set   = 1'b0;
        tmo_d     = '0;

        unique case (state_q)
            StIdle: begin
                if (fall) begin
                    if (!data_sync_q) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            StData: begin
                if (fall) begin
                    shift_d   = {data_sync_q, shift_q[7:1]};
                    bit_cnt_d = 3'(bit_cnt_q + 3'd1);
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
            end
            StParity: begin
                if (fall) begin
                    parity_d = data_sync_q;
                    state_d  = StStop;
                end
            end
            StStop: begin
                if (fall) begin
                    state_d = StIdle;
                    if (data_sync_q && (^{shift_q, parity_q})) begin
                        if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            rel_d = 1'b1;
                        end else begin
                            valid_set = 1'b1;
                        end
                    end else begin
                        err_set = 1'b1;
                        ext_d   = 1'b0;
                        rel_d   = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_q != StIdle && !fall) begin
            if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                state_d = StIdle;
                err_set = 1'b1;
                ext_d   = 1'b0;
                rel_d   = 1'b0;
            end else begin
                tmo_d = tmo_q + TmoW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta_q     <= 1'b1;
            clk_sync_q     <= 1'b1;
            data_meta_q    <= 1'b1;
            data_sync_q    <= 1'b1;
            hist_q         <= '1;
            filt_q         <= 1'b1;
            state_q        <= StIdle;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            parity_q       <= 1'b0;
            tmo_q          <= '0;
            ext_q          <= 1'b0;
            rel_q          <= 1'b0;
            scancode       <= '0;
            extended       <= 1'b0;
            released       <= 1'b0;
            scancode_valid <= 1'b0;
            frame_error    <= 1'b0;
        end else begin
            clk_meta_q     <= clkps2;
            clk_sync_q     <= clk_meta_q;
            data_meta_q    <= dataps2;
            data_sync_q    <= data_meta_q;
            hist_q         <= {hist_q[FILTER_LEN-2:0], clk_sync_q};
            filt_q         <= filt_d;
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            parity_q       <= parity_d;
            tmo_q          <= tmo_d;
            scancode_valid <= valid_set;
            frame_error    <= err_set;
            if (valid_set) begin
                scancode <= shift_q;
                extended <= ext_q;
                released <= rel_q;
                ext_q    <= 1'b0;
                rel_q    <= 1'b0;
            end else begin
                ext_q <= ext_d;
                rel_q <= rel_d;
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Randomised self-checking bench for ps2_scancode_rx against an event-level reference model.
`timescale 1ns/1ps
module tb_ps2_scancode_rx;

    localparam int FL = 8;
    localparam int TO = 32000;
    localparam int LAT = FL + 3;  // pin edge -> 2 sync flops -> filter fill -> output register

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clkps2 = 1'b1;
    logic       dataps2 = 1'b1;
    logic [7:0] scancode;
    logic       extended, released, scancode_valid, frame_error;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_fall = 0;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } ev_t;

    ev_t got_q[$];
    int  got_cyc[$];
    int  err_cyc[$];
    ev_t exp_q[$];
    int  exp_err = 0;
    logic m_ext = 1'b0;
    logic m_rel = 1'b0;

    ps2_scancode_rx #(
        .FILTER_LEN    (FL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clkps2        (clkps2),
        .dataps2       (dataps2),
        .scancode      (scancode),
        .extended      (extended),
        .released      (released),
        .scancode_valid(scancode_valid),
        .frame_error   (frame_error)
    );

    always #31 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (scancode_valid) begin
            got_q.push_back('{code: scancode, ext: extended, rel: released});
            got_cyc.push_back(cyc);
        end
        if (frame_error) err_cyc.push_back(cyc);
        if (scancode_valid || frame_error) begin
            checks++;
            if (scancode_valid && frame_error) begin
                errors++;
                $display("FAIL exclusive: valid=%b error=%b at cycle %0d, required not both",
                         scancode_valid, frame_error, cyc);
            end
        end
    end

    // Reference model: what a correct receiver reports for one received byte.
    task automatic model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            exp_err++;
            m_ext = 1'b0;
            m_rel = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_rel = 1'b1;
        end else begin
            exp_q.push_back('{code: b, ext: m_ext, rel: m_rel});
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
    endtask

    task automatic clear_logs();
        got_q.delete();
        got_cyc.delete();
        err_cyc.delete();
        exp_q.delete();
        exp_err = 0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic d, input int half, input bit glitch);
        dataps2 = d;
        wait_cyc(half / 2);
        clkps2 = 1'b0;
        last_fall = cyc;
        wait_cyc(half);
        clkps2 = 1'b1;
        if (glitch) begin
            wait_cyc(half / 4);
            clkps2 = 1'b0;
            wait_cyc(5);
            clkps2 = 1'b1;
            wait_cyc(half / 2 - half / 4 - 5);
        end else begin
            wait_cyc(half / 2);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int half,
                              input bit glitch);
        logic p;
        p = (~^b) ^ bad_par;
        send_bit(1'b0, half, glitch);
        for (int i = 0; i < 8; i++) send_bit(b[i], half, glitch);
        send_bit(p, half, glitch);
        send_bit(1'b1, half, glitch);
        dataps2 = 1'b1;
        wait_cyc(20);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_cyc(5);
        checks++;
        if ({scancode, extended, released, scancode_valid, frame_error} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 000",
                     {scancode, extended, released, scancode_valid, frame_error});
        end
        reset = 1'b0;
        wait_cyc(20);
        checks++;
        if (got_q.size() + err_cyc.size() != 0) begin
            errors++;
            $display("FAIL reset_quiet: got %0d strobes, required 0",
                     got_q.size() + err_cyc.size());
        end
    endtask

    task automatic test_make();
        clear_logs();
        model_byte(8'h1C, 1'b1);
        send_frame(8'h1C, 1'b0, 640, 1'b0);
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL make_count: got %0d strobes, required 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== exp_q[0]) begin
                errors++;
                $display("FAIL make_event: got %h, required %h", got_q[0], exp_q[0]);
            end
            checks++;
            if (got_cyc[0] - last_fall != LAT) begin
                errors++;
                $display("FAIL make_latency: got %0d, required %0d", got_cyc[0] - last_fall, LAT);
            end
        end
        wait_cyc(100);
        checks++;
        if ({scancode, extended, released} !== {8'h1C, 2'b00}) begin
            errors++;
            $display("FAIL make_hold: got %h, required %h", {scancode, extended, released},
                     {8'h1C, 2'b00});
        end
        checks++;
        if (err_cyc.size() != 0) begin
            errors++;
            $display("FAIL make_errors: got %0d, required 0", err_cyc.size());
        end
    endtask

    task automatic test_ext_break();
        logic [7:0] seq[4];
        seq = '{8'hE0, 8'hF0, 8'h75, 8'h75};
        clear_logs();
        foreach (seq[i]) begin
            model_byte(seq[i], 1'b1);
            send_frame(seq[i], 1'b0, 80, 1'b0);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL ext_count: got %0d, required %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL ext_event%0d: got %h, required %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_parity();
        clear_logs();
        model_byte(8'h1C, 1'b0);
        send_frame(8'h1C, 1'b1, 80, 1'b0);
        checks++;
        if (err_cyc.size() != exp_err || got_q.size() != 0) begin
            errors++;
            $display("FAIL parity_err: got errors=%0d valids=%0d, required errors=%0d valids=0",
                     err_cyc.size(), got_q.size(), exp_err);
        end
        model_byte(8'h32, 1'b1);
        send_frame(8'h32, 1'b0, 80, 1'b0);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL parity_recover: got %0d events first=%h, required 1 event %h",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : ev_t'(0), exp_q[0]);
        end
    endtask

    task automatic test_timeout();
        int d;
        clear_logs();
        send_bit(1'b0, 80, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(i & 1), 80, 1'b0);
        dataps2 = 1'b1;
        wait_cyc(40000);
        checks++;
        if (err_cyc.size() != 1 || got_q.size() != 0) begin
            errors++;
            $display("FAIL timeout_count: got errors=%0d valids=%0d, required 1 and 0",
                     err_cyc.size(), got_q.size());
        end else begin
            d = err_cyc[0] - last_fall - LAT;
            checks++;
            if (d < TO - 1 || d > TO + 1) begin
                errors++;
                $display("FAIL timeout_delay: got %0d cycles, required %0d +/-1", d, TO);
            end
        end
        clear_logs();
        model_byte(8'h29, 1'b1);
        send_frame(8'h29, 1'b0, 80, 1'b0);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0] || err_cyc.size() != 0) begin
            errors++;
            $display("FAIL timeout_recover: got %0d events errors=%0d, required 1 event %h",
                     got_q.size(), err_cyc.size(), exp_q[0]);
        end
    endtask

    task automatic test_glitch();
        clear_logs();
        model_byte(8'h4D, 1'b1);
        send_frame(8'h4D, 1'b0, 80, 1'b1);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0] || err_cyc.size() != 0) begin
            errors++;
            $display("FAIL glitch: got %0d events errors=%0d, required 1 event %h no errors",
                     got_q.size(), err_cyc.size(), exp_q[0]);
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        send_bit(1'b0, 80, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 80, 1'b0);
        reset = 1'b1;
        wait_cyc(4);
        reset = 1'b0;
        m_ext = 1'b0;
        m_rel = 1'b0;
        wait_cyc(100);
        checks++;
        if (got_q.size() + err_cyc.size() != 0 || {scancode, extended, released} !== 10'h0) begin
            errors++;
            $display("FAIL reset_mid: got strobes=%0d outputs=%h, required 0 and 000",
                     got_q.size() + err_cyc.size(), {scancode, extended, released});
        end
        model_byte(8'h5A, 1'b1);
        send_frame(8'h5A, 1'b0, 80, 1'b0);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL reset_recover: got %0d events, required 1 event %h",
                     got_q.size(), exp_q[0]);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        bit         good;
        clear_logs();
        for (int n = 0; n < 8; n++) begin
            case ($urandom_range(0, 4))
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: b = 8'hE1;
                default: b = 8'($urandom);
            endcase
            good = ($urandom_range(0, 5) != 0);
            model_byte(b, good);
            send_frame(b, !good, 60, 1'($urandom_range(0, 1)));
        end
        checks++;
        if (err_cyc.size() != exp_err) begin
            errors++;
            $display("FAIL random_errors: got %0d, required %0d", err_cyc.size(), exp_err);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random_count: got %0d, required %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL random_event%0d: got %h, required %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_make();
        test_ext_break();
        test_parity();
        test_timeout();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
